pipe_hazard_ctrl: RTL and testbench

//  Generalised hazard/stall controller for the 5-stage MIPS pipeline. Adds a variable-latency

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// E-stage operand forward selects.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational forwarding comparators for the D-stage branch compare and
// the E-stage ALU operands. Register 0 is never forwarded.
module pipe_hazard_ctrl_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth = 5
) (
  input  logic [AddrWidth-1:0] rs_d,
  input  logic [AddrWidth-1:0] rt_d,
  input  logic [AddrWidth-1:0] rs_e,
  input  logic [AddrWidth-1:0] rt_e,
  input  logic [AddrWidth-1:0] write_reg_m,
  input  logic [AddrWidth-1:0] write_reg_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  output fwd_sel_t             fwd_a_e,
  output fwd_sel_t             fwd_b_e,
  output logic                 fwd_a_d,
  output logic                 fwd_b_d
);

  logic m_ok, w_ok;

  assign m_ok = reg_write_m && (write_reg_m != '0);
  assign w_ok = reg_write_w && (write_reg_w != '0);

  // M has priority over W: it holds the younger result.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (m_ok && (write_reg_m == rs_e))      fwd_a_e = FWD_MEM;
    else if (w_ok && (write_reg_w == rs_e)) fwd_a_e = FWD_WB;

    fwd_b_e = FWD_RF;
    if (m_ok && (write_reg_m == rt_e))      fwd_b_e = FWD_MEM;
    else if (w_ok && (write_reg_w == rt_e)) fwd_b_e = FWD_WB;
  end

  assign fwd_a_d = m_ok && (write_reg_m == rs_d);
  assign fwd_b_d = m_ok && (write_reg_m == rt_d);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: forwarding, load-use and
// branch stalls, variable-latency data-memory wait with timeout, stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RF_ADDR_WIDTH  = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_WIDTH      = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_JrD,
  input  logic                     i_PCSrcD,
  input  logic                     i_MemOpM,
  input  logic                     i_MemReady,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_FlushD,
  output logic                     o_FlushE,
  output logic                     o_FlushW,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_MemReq,
  output logic                     o_MemErr,
  output logic [CNT_WIDTH-1:0]     o_StallCnt
);

  state_e               state_q;
  logic [TMO_WIDTH-1:0] wait_cnt_q;
  logic                 mem_err_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  fwd_sel_t fwd_ae, fwd_be;
  logic     fwd_ad, fwd_bd;
  logic     lwstall, brstall, memstall, e_hit, m_hit;

  pipe_hazard_ctrl_fwd_unit #(
    .AddrWidth(RF_ADDR_WIDTH)
  ) u_fwd_unit (
    .rs_d       (i_RsD),
    .rt_d       (i_RtD),
    .rs_e       (i_RsE),
    .rt_e       (i_RtE),
    .write_reg_m(i_WriteRegM),
    .write_reg_w(i_WriteRegW),
    .reg_write_m(i_RegWriteM),
    .reg_write_w(i_RegWriteW),
    .fwd_a_e    (fwd_ae),
    .fwd_b_e    (fwd_be),
    .fwd_a_d    (fwd_ad),
    .fwd_b_d    (fwd_bd)
  );

  assign lwstall = i_MemtoRegE && (i_WriteRegE != '0) &&
                   ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD));

  // JR reads only Rs; a conditional branch compares Rs and Rt.
  assign e_hit = i_RegWriteE && (i_WriteRegE != '0) &&
                 ((i_WriteRegE == i_RsD) || (i_BranchD && (i_WriteRegE == i_RtD)));
  assign m_hit = i_MemtoRegM && (i_WriteRegM != '0) &&
                 ((i_WriteRegM == i_RsD) || (i_BranchD && (i_WriteRegM == i_RtD)));
  assign brstall = (i_BranchD || i_JrD) && (e_hit || m_hit);

  assign memstall = i_MemOpM && !i_MemReady && (state_q != StErr);

  always_comb begin
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_StallE    = 1'b0;
    o_StallM    = 1'b0;
    o_FlushD    = 1'b0;
    o_FlushE    = 1'b0;
    o_FlushW    = 1'b0;
    o_ForwardAD = 1'b0;
    o_ForwardBD = 1'b0;
    o_ForwardAE = FWD_RF;
    o_ForwardBE = FWD_RF;
    o_MemReq    = 1'b0;
    if (i_RST) begin
      o_ForwardAD = fwd_ad;
      o_ForwardBD = fwd_bd;
      o_ForwardAE = fwd_ae;
      o_ForwardBE = fwd_be;
      o_MemReq    = i_MemOpM && (state_q != StErr);
      // Memory wait freezes the whole pipe and masks the younger hazards.
      if (memstall || (state_q == StErr)) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_StallM = 1'b1;
        o_FlushW = 1'b1;
      end else if (lwstall || brstall) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_FlushE = 1'b1;
      end else begin
        o_FlushD = i_PCSrcD;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (o_StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      unique case (state_q)
        StRun: begin
          wait_cnt_q <= '0;
          if (memstall) state_q <= StMemWait;
        end
        StMemWait: begin
          if (!memstall) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q + 1'b1 == TMO_WIDTH'(TIMEOUT_CYCLES)) begin
            state_q   <= StErr;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StErr:   mem_err_q <= 1'b1;
        default: state_q   <= StRun;
      endcase
    end
  end

  assign o_MemErr   = mem_err_q;
  assign o_StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance and a short-timeout,
// narrow-counter instance share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, jr_d, pcsrc_d, memop_m, mem_ready;

  logic        sf, sd, se, sm, fd, fe, fw, ad, bd, req, err;
  logic [1:0]  ae, be;
  logic [15:0] cnt;

  logic        t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fw, t_ad, t_bd, t_req, t_err;
  logic [1:0]  t_ae, t_be;
  logic [3:0]  t_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  pipe_hazard_ctrl dut (
    .i_CLK(clk), .i_RST(rst), .i_RsD(rs_d), .i_RtD(rt_d), .i_RsE(rs_e), .i_RtE(rt_e),
    .i_WriteRegE(wr_e), .i_WriteRegM(wr_m), .i_WriteRegW(wr_w),
    .i_RegWriteE(rw_e), .i_RegWriteM(rw_m), .i_RegWriteW(rw_w),
    .i_MemtoRegE(m2r_e), .i_MemtoRegM(m2r_m), .i_BranchD(br_d), .i_JrD(jr_d),
    .i_PCSrcD(pcsrc_d), .i_MemOpM(memop_m), .i_MemReady(mem_ready),
    .o_StallF(sf), .o_StallD(sd), .o_StallE(se), .o_StallM(sm),
    .o_FlushD(fd), .o_FlushE(fe), .o_FlushW(fw), .o_ForwardAD(ad), .o_ForwardBD(bd),
    .o_ForwardAE(ae), .o_ForwardBE(be), .o_MemReq(req), .o_MemErr(err), .o_StallCnt(cnt)
  );

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES(3),
    .CNT_WIDTH     (4)
  ) dut_t (
    .i_CLK(clk), .i_RST(rst), .i_RsD(rs_d), .i_RtD(rt_d), .i_RsE(rs_e), .i_RtE(rt_e),
    .i_WriteRegE(wr_e), .i_WriteRegM(wr_m), .i_WriteRegW(wr_w),
    .i_RegWriteE(rw_e), .i_RegWriteM(rw_m), .i_RegWriteW(rw_w),
    .i_MemtoRegE(m2r_e), .i_MemtoRegM(m2r_m), .i_BranchD(br_d), .i_JrD(jr_d),
    .i_PCSrcD(pcsrc_d), .i_MemOpM(memop_m), .i_MemReady(mem_ready),
    .o_StallF(t_sf), .o_StallD(t_sd), .o_StallE(t_se), .o_StallM(t_sm),
    .o_FlushD(t_fd), .o_FlushE(t_fe), .o_FlushW(t_fw), .o_ForwardAD(t_ad),
    .o_ForwardBD(t_bd), .o_ForwardAE(t_ae), .o_ForwardBE(t_be), .o_MemReq(t_req),
    .o_MemErr(t_err), .o_StallCnt(t_cnt)
  );

  // Packed view: {StallF,D,E,M, FlushD,E,W, FwdAD,BD, FwdAE[1:0], FwdBE[1:0], MemReq}
  function automatic logic [13:0] obs();
    return {sf, sd, se, sm, fd, fe, fw, ad, bd, ae, be, req};
  endfunction

  function automatic logic [13:0] t_obs();
    return {t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fw, t_ad, t_bd, t_ae, t_be, t_req};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; wr_e = '0; wr_m = '0; wr_w = '0;
    rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; m2r_m = 0; br_d = 0; jr_d = 0;
    pcsrc_d = 0; memop_m = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    memop_m = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 14'd0) begin
        failures++; $display("FAIL reset_outs got=%b exp=%b", obs(), 14'd0);
      end
      checks++;
      if (cnt !== 16'd0 || err !== 1'b0) begin
        failures++; $display("FAIL reset_regs cnt=%0d err=%b exp cnt=0 err=0", cnt, err);
      end
      tick();
    end
    rst = 1'b1;
    memop_m = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    checks++;
    if (obs() !== 14'd0 || cnt !== 16'd0) begin
      failures++; $display("FAIL post_reset got=%b cnt=%0d exp=%b cnt=0", obs(), cnt, 14'd0);
    end
    tick();
  endtask

  task automatic test_forward();
    logic [13:0] exp_v [6];
    exp_v[0] = 14'b0000_000_00_10_10_0;
    exp_v[1] = 14'b0000_000_00_01_01_0;
    exp_v[2] = 14'b0000_000_00_00_00_0;
    exp_v[3] = 14'b0000_000_11_00_00_0;
    exp_v[4] = 14'b0000_000_00_00_00_0;
    exp_v[5] = 14'b0000_000_00_10_01_0;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin rs_e = 5; rt_e = 5; wr_m = 5; rw_m = 1; wr_w = 5; rw_w = 1; end
        1: begin rs_e = 5; rt_e = 5; wr_m = 0; rw_m = 1; wr_w = 5; rw_w = 1; end
        2: begin rs_e = 5; rt_e = 5; wr_m = 0; rw_m = 1; wr_w = 5; rw_w = 0; end
        3: begin rs_d = 5; rt_d = 5; wr_m = 5; rw_m = 1; end
        4: begin rw_m = 1; rw_w = 1; end
        default: begin rs_e = 5; rt_e = 6; wr_m = 5; rw_m = 1; wr_w = 6; rw_w = 1; end
      endcase
      @(negedge clk);
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL forward_%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [13:0] exp_v [5];
    exp_v[0] = 14'b1100_010_00_00_00_0;
    exp_v[1] = 14'b0000_000_00_00_00_0;
    exp_v[2] = 14'b1100_010_00_00_00_0;
    exp_v[3] = 14'b0000_000_00_00_00_0;
    exp_v[4] = 14'b1100_010_00_00_00_0;
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin m2r_e = 1; wr_e = 3; rs_d = 3; end
        1: begin m2r_e = 1; end
        2: begin br_d = 1; rw_e = 1; wr_e = 7; rt_d = 7; end
        3: begin jr_d = 1; rw_e = 1; wr_e = 7; rt_d = 7; end
        default: begin br_d = 1; m2r_m = 1; wr_m = 9; rs_d = 9; end
      endcase
      @(negedge clk);
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL hazard_%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      tick();
    end
    idle();
    exp_cnt += 3;
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      failures++; $display("FAIL hazard_stallcnt got=%0d exp=%0d", cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    memop_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 14'b1111_001_00_00_00_1) begin
        failures++; $display("FAIL memwait_%0d got=%b exp=%b", i, obs(), 14'b1111_001_00_00_00_1);
      end
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 14'b0000_000_00_00_00_1) begin
      failures++; $display("FAIL memwait_ready got=%b exp=%b", obs(), 14'b0000_000_00_00_00_1);
    end
    tick();
    idle();
    exp_cnt += 4;
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt) || err !== 1'b0 || obs() !== 14'd0) begin
      failures++;
      $display("FAIL memwait_after cnt=%0d err=%b outs=%b exp cnt=%0d err=0 outs=0",
               cnt, err, obs(), exp_cnt);
    end
    tick();
  endtask

  task automatic test_priority();
    idle();
    pcsrc_d = 1'b1;
    memop_m = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 14'b1111_001_00_00_00_1) begin
        failures++; $display("FAIL prio_wait_%0d got=%b exp=%b", i, obs(), 14'b1111_001_00_00_00_1);
      end
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 14'b0000_100_00_00_00_1) begin
      failures++; $display("FAIL prio_ready got=%b exp=%b", obs(), 14'b0000_100_00_00_00_1);
    end
    tick();
    idle();
    pcsrc_d = 1'b1;
    m2r_e = 1'b1; wr_e = 3; rs_d = 3;
    @(negedge clk);
    checks++;
    if (obs() !== 14'b1100_010_00_00_00_0) begin
      failures++; $display("FAIL prio_lw_pcsrc got=%b exp=%b", obs(), 14'b1100_010_00_00_00_0);
    end
    tick();
    idle();
    exp_cnt += 3;
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      failures++; $display("FAIL prio_stallcnt got=%0d exp=%0d", cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit found;
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    memop_m = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (t_err === 1'b1) found = 1'b1;
      tick();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL timeout_reach got=%b exp=1", t_err);
    end
    memop_m = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (t_err !== 1'b1 || t_obs() !== 14'b1111_001_00_00_00_0) begin
      failures++;
      $display("FAIL timeout_hold err=%b outs=%b exp err=1 outs=%b", t_err, t_obs(),
               14'b1111_001_00_00_00_0);
    end
    checks++;
    if (t_cnt !== 4'hF) begin
      failures++; $display("FAIL stallcnt_sat got=%0d exp=15", t_cnt);
    end
    memop_m = 1'b1;
    @(negedge clk);
    checks++;
    if (t_obs() !== 14'b1111_001_00_00_00_0) begin
      failures++; $display("FAIL err_no_req got=%b exp=%b", t_obs(), 14'b1111_001_00_00_00_0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (t_obs() !== 14'd0) begin
      failures++; $display("FAIL err_reset_outs got=%b exp=%b", t_obs(), 14'd0);
    end
    tick();
    rst = 1'b1;
    memop_m = 1'b0;
    @(negedge clk);
    checks++;
    if (t_err !== 1'b0 || t_obs() !== 14'd0 || t_cnt !== 4'd0) begin
      failures++;
      $display("FAIL err_cleared err=%b outs=%b cnt=%0d exp err=0 outs=0 cnt=0",
               t_err, t_obs(), t_cnt);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_priority();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
